scc_mapper_ctrl: RTL and testbench
==================================

Name: scc_mapper_ctrl

Overview:
Konami SCC/SCC+ cartridge mapper and bus sequencer between the MSX cartridge bus slave and two targets: the SCC sound core and the external ROM/RAM memory controller.
- Holds the four 8 KB bank registers and the SCC+ mode register.
- Generates scc_bank_en, sccp_bank_en and sccp_en for the SCC core.
- Routes each memory access to the SCC core, the memory, or the internal registers.
- Sequences the read handshake, with timeout, back to the bus.

Parameters:
TIMEOUT, 63, cycles to wait for a target read response before aborting silently
SCCP_SUPPORT, 1, 1 = mode register at BFFEh/BFFFh is writable; 0 = mode register stays 00h

Ports:
clk  in  1  system clock
n_reset  in  1  reset, asynchronous, active-low
bus_address  in  16  CPU address, valid with bus_read/bus_write
bus_write_data  in  8  CPU write data
bus_read  in  1  one-cycle read request pulse
bus_write  in  1  one-cycle write request pulse
bus_memory  in  1  1 = memory cycle (I/O cycles are ignored)
bus_read_ready  out  1  one-cycle pulse: bus_read_data valid
bus_read_data  out  8  read data, held until the next ready pulse
scc_address  out  16  address forwarded to the SCC core
scc_write_data  out  8  write data forwarded to the SCC core
scc_read  out  1  one-cycle read pulse to the SCC core
scc_write  out  1  one-cycle write pulse to the SCC core
scc_read_ready  in  1  SCC read data valid
scc_read_data  in  8  SCC read data
scc_bank_en  out  1  SCC register window 9800h-9FFFh active
sccp_bank_en  out  1  SCC+ register window B800h-BFFFh active
sccp_en  out  1  SCC+ mode
mem_address  out  21  {bank[7:0], bus_address[12:0]}
mem_read  out  1  read request, held until accepted
mem_write  out  1  write request, held until accepted
mem_write_data  out  8  memory write data
mem_busy  in  1  1 = request not accepted this cycle
mem_read_data  in  8  memory read data
mem_read_valid  in  1  memory read data valid

Behaviour:
- Reset values:
  - bank0..3 = 00h,01h,02h,03h; mode = 00h.
  - All strobes 0; bus_read_data = 00h; addresses/data = 0.
  - FSM in IDLE.
- Bank window n: address[15:13] = 2+n, i.e. 4000h-BFFFh. Addresses outside 4000h-BFFFh are ignored entirely: no forwarding, no ready.
- Register decode:
  - Bank register n: address[15:11] = {2+n, 2'b10}, i.e. 5000h/7000h/9000h/B000h + 000h-7FFh.
  - Mode register: BFFEh-BFFFh.
- Derived signals:
  - RAM-writable(n) = mode[4] | mode[n], for n = 0..2; bank3 uses mode[4] only.
  - sccp_en = mode[5].
  - scc_bank_en = !mode[5] & (bank2[5:0] = 3Fh).
  - sccp_bank_en = mode[5] & bank3[7].
  - All three are combinational from the registers and update the cycle after the register write.
- Routing priority, evaluated on the accept edge:
  1. SCC window: 9800h-9FFFh with scc_bank_en, or B800h-BFFFh with sccp_bank_en → SCC.
  2. Write to mode register → mode (write ignored when SCCP_SUPPORT = 0).
  3. Write to bank register n:
     - bank n not RAM-writable → bank n register updated, nothing forwarded;
     - bank n RAM-writable → forwarded to memory, register unchanged.
  4. Other write: bank RAM-writable → memory; otherwise dropped.
  5. Read → memory.
- FSM states: IDLE, SCC_RD, MEM_REQ, MEM_RD.
  - IDLE accepts bus_read or bus_write only when bus_memory = 1 and the address is in range.
  - SCC write: scc_write pulses 1 cycle after accept; FSM stays in IDLE.
  - SCC read: scc_read pulses 1 cycle after accept → SCC_RD. On scc_read_ready: latch data, pulse bus_read_ready the next cycle → IDLE.
  - Memory access → MEM_REQ. mem_read/mem_write asserted from the cycle after accept and held while mem_busy = 1.
    - Write accepted (mem_busy = 0) → IDLE, no ready pulse.
    - Read accepted → MEM_RD. On mem_read_valid: latch data, pulse bus_read_ready the next cycle → IDLE.
- Minimum read latency: 3 cycles from the request pulse to bus_read_ready (zero-wait target).
- Timeout counter:
  - Cleared on accept; counts in SCC_RD, MEM_REQ and MEM_RD.
  - On reaching TIMEOUT: drop strobes → IDLE, no ready pulse, bus_read_data unchanged.
- Requests arriving while the FSM is not in IDLE are ignored (one outstanding access only). A request coinciding with the return to IDLE is also ignored.
- bus_read and bus_write high together: read wins.
- Reset asserted mid-transaction: all outputs and state return to reset values immediately; a late scc_read_ready or mem_read_valid after reset is ignored.

Test Plan:
- After reset, read 9800h; memory returns 11h → mem_read with mem_address = 05800h; scc_read never pulses; bus_read_ready with data 11h; scc_bank_en = 0.
- Write 9000h = 3Fh, then read 9880h; SCC returns 5Ah after 3 cycles → scc_bank_en = 1; scc_read pulse with scc_address = 9880h; bus_read_ready with data 5Ah; no mem_read.
- Write BFFEh = 20h, then B000h = 80h → sccp_en = 1, sccp_bank_en = 1, scc_bank_en = 0 (bank2 still 3Fh); read B800h goes to SCC.
- Write BFFEh = 10h, then 6000h = AAh and 7000h = 55h → two mem_write cycles at addresses 02000h and 03000h; bank1 remains 01h.
- Hold mem_busy = 1 for 5 cycles on a read → mem_read held for 6 cycles, then accepted; with mem_read_valid never asserted → no bus_read_ready, FSM back to IDLE after 63 cycles; the next read is served normally.
- Issue reads to 0000h and C000h, a second read during MEM_RD, and assert reset mid-SCC_RD → no forwarding and no ready for any of them; after reset, bank registers read back as 0/1/2/3 via mem_address.

Source files
------------

// File: rtl/scc_mapper_ctrl.sv
// Konami SCC/SCC+ cartridge mapper and bus sequencer.
// Holds the four 8 KB bank registers and the SCC+ mode register. Each accepted bus access
// goes to the SCC core, the external memory or an internal register. Read data returns
// to the bus through a single-outstanding handshake that gives up silently after TIMEOUT
// busy cycles.
module scc_mapper_ctrl #(
  parameter int unsigned TIMEOUT      = 63,
  parameter int unsigned SCCP_SUPPORT = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic        bus_memory,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  output logic [15:0] scc_address,
  output logic [7:0]  scc_write_data,
  output logic        scc_read,
  output logic        scc_write,
  input  logic        scc_read_ready,
  input  logic [7:0]  scc_read_data,
  output logic        scc_bank_en,
  output logic        sccp_bank_en,
  output logic        sccp_en,
  output logic [20:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_write_data,
  input  logic        mem_busy,
  input  logic [7:0]  mem_read_data,
  input  logic        mem_read_valid
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSccRd, StMemReq, StMemRd} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0][7:0] bank_q, bank_d;
  logic [7:0]      mode_q, mode_d;
  logic [15:0]     scc_address_q, scc_address_d;
  logic [7:0]      scc_wdata_q, scc_wdata_d;
  logic            scc_read_q, scc_read_d, scc_write_q, scc_write_d;
  logic [20:0]     mem_address_q, mem_address_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic            rdy_q, rdy_d;
  logic [7:0]      rdata_q, rdata_d;

  logic       in_range, req, scc_hit, mode_hit, bank_reg_hit, timed_out;
  logic [1:0] idx;
  logic [3:0] ram_wr;

  // Address decode of the current bus request
  assign in_range     = bus_address[15] ^ bus_address[14];  // 4000h-BFFFh
  assign idx          = {~bus_address[14], bus_address[13]};
  assign mode_hit     = (bus_address[15:1] == 15'h5fff);
  assign bank_reg_hit = (bus_address[12:11] == 2'b10);
  assign scc_hit      = ((bus_address[15:11] == 5'b10011) & scc_bank_en) |
                        ((bus_address[15:11] == 5'b10111) & sccp_bank_en);
  assign req          = (bus_read | bus_write) & bus_memory & in_range & (state_q == StIdle);

  assign ram_wr = {mode_q[4], mode_q[4] | mode_q[2], mode_q[4] | mode_q[1],
                   mode_q[4] | mode_q[0]};

  assign timed_out = (cnt_q >= CntLast);
  // Saturate so a late memory accept cannot wrap the counter past the limit
  assign cnt_inc   = timed_out ? cnt_q : cnt_q + 1'b1;

  assign sccp_en      = mode_q[5];
  assign scc_bank_en  = ~mode_q[5] & (bank_q[2][5:0] == 6'h3f);
  assign sccp_bank_en = mode_q[5] & bank_q[3][7];

  assign bus_read_ready = rdy_q;
  assign bus_read_data  = rdata_q;
  assign scc_address    = scc_address_q;
  assign scc_write_data = scc_wdata_q;
  assign scc_read       = scc_read_q;
  assign scc_write      = scc_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

  // Next-state: request routing, handshake sequencing and timeout
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bank_d        = bank_q;
    mode_d        = mode_q;
    scc_address_d = scc_address_q;
    scc_wdata_d   = scc_wdata_q;
    scc_read_d    = 1'b0;
    scc_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    rdy_d         = 1'b0;
    rdata_d       = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = '0;
          if (scc_hit) begin
            scc_address_d = bus_address;
            if (bus_read) begin
              scc_read_d = 1'b1;
              state_d    = StSccRd;
            end else begin
              scc_write_d = 1'b1;
              scc_wdata_d = bus_write_data;
            end
          end else if (bus_read) begin
            mem_address_d = {bank_q[idx], bus_address[12:0]};
            mem_read_d    = 1'b1;
            state_d       = StMemReq;
          end else if (mode_hit) begin
            if (SCCP_SUPPORT != 0) mode_d = bus_write_data;
          end else if (bank_reg_hit && !ram_wr[idx]) begin
            bank_d[idx] = bus_write_data;
          end else if (ram_wr[idx]) begin
            mem_address_d = {bank_q[idx], bus_address[12:0]};
            mem_wdata_d   = bus_write_data;
            mem_write_d   = 1'b1;
            state_d       = StMemReq;
          end
        end
      end
      StSccRd: begin
        cnt_d = cnt_inc;
        if (scc_read_ready) begin
          rdata_d = scc_read_data;
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else if (timed_out) begin
          state_d = StIdle;
        end
      end
      StMemReq: begin
        cnt_d = cnt_inc;
        if (!mem_busy) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = mem_read_q ? StMemRd : StIdle;
        end else if (timed_out) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StMemRd: begin
        cnt_d = cnt_inc;
        if (mem_read_valid) begin
          rdata_d = mem_read_data;
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else if (timed_out) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bank_q        <= {8'h03, 8'h02, 8'h01, 8'h00};
      mode_q        <= 8'h00;
      scc_address_q <= 16'h0000;
      scc_wdata_q   <= 8'h00;
      scc_read_q    <= 1'b0;
      scc_write_q   <= 1'b0;
      mem_address_q <= 21'h000000;
      mem_wdata_q   <= 8'h00;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      rdy_q         <= 1'b0;
      rdata_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bank_q        <= bank_d;
      mode_q        <= mode_d;
      scc_address_q <= scc_address_d;
      scc_wdata_q   <= scc_wdata_d;
      scc_read_q    <= scc_read_d;
      scc_write_q   <= scc_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      rdy_q         <= rdy_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_scc_mapper_ctrl.sv
// Directed bench for scc_mapper_ctrl: a vector table of bus accesses with hand-computed
// routing/handshake results, plus sequences for stall/timeout, busy-FSM requests and reset.
module tb_scc_mapper_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read, bus_write, bus_memory;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [15:0] scc_address;
  logic [7:0]  scc_write_data;
  logic        scc_read, scc_write;
  logic        scc_read_ready;
  logic [7:0]  scc_read_data;
  logic        scc_bank_en, sccp_bank_en, sccp_en;
  logic [20:0] mem_address;
  logic        mem_read, mem_write;
  logic [7:0]  mem_write_data;
  logic        mem_busy;
  logic [7:0]  mem_read_data;
  logic        mem_read_valid;

  scc_mapper_ctrl #(.TIMEOUT(63), .SCCP_SUPPORT(1)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .bus_address    (bus_address),
    .bus_write_data (bus_write_data),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_memory     (bus_memory),
    .bus_read_ready (bus_read_ready),
    .bus_read_data  (bus_read_data),
    .scc_address    (scc_address),
    .scc_write_data (scc_write_data),
    .scc_read       (scc_read),
    .scc_write      (scc_write),
    .scc_read_ready (scc_read_ready),
    .scc_read_data  (scc_read_data),
    .scc_bank_en    (scc_bank_en),
    .sccp_bank_en   (sccp_bank_en),
    .sccp_en        (sccp_en),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_busy       (mem_busy),
    .mem_read_data  (mem_read_data),
    .mem_read_valid (mem_read_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd, wr, memc;
    logic [15:0] addr;
    logic [7:0]  wd, resp;
    int          rwait;
    int          e_scc_rd, e_scc_wr, e_mem_rd, e_mem_wr;
    logic [15:0] e_scc_addr;
    logic [7:0]  e_wdata;
    logic [20:0] e_mem_addr;
    int          e_rdy;
    logic [7:0]  e_rdata;
    int          e_lat;
    logic [2:0]  e_flags;  // {scc_bank_en, sccp_bank_en, sccp_en} after the access
  } vec_t;

  vec_t vecs[23];
  vec_t post[4];

  int checks = 0;
  int errors = 0;

  int          o_scc_rd, o_scc_wr, o_mem_rd, o_mem_wr, o_rdy, o_lat;
  logic [15:0] o_scc_addr;
  logic [7:0]  o_scc_wdata, o_mem_wdata, o_rdata;
  logic [20:0] o_mem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus access, then watch span cycles while acting as SCC core and memory.
  // rwait < 0 means the target never answers.
  task automatic run(input logic rd, input logic wr, input logic memc, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] resp, input int rwait,
                     input int busy, input int span);
    int scc_due, mem_due;
    scc_due = -1;
    mem_due = -1;
    o_scc_rd = 0; o_scc_wr = 0; o_mem_rd = 0; o_mem_wr = 0; o_rdy = 0; o_lat = 0;
    o_scc_addr = '0; o_scc_wdata = '0; o_mem_wdata = '0; o_rdata = '0; o_mem_addr = '0;
    @(negedge clk);
    bus_read = rd; bus_write = wr; bus_memory = memc; bus_address = a; bus_write_data = wd;
    @(negedge clk);
    bus_read = 1'b0; bus_write = 1'b0; bus_memory = 1'b0;
    for (int c = 1; c <= span; c++) begin
      if (scc_read) begin
        o_scc_rd++;
        o_scc_addr = scc_address;
        if (rwait >= 0) scc_due = c + rwait;
      end
      if (scc_write) begin
        o_scc_wr++;
        o_scc_addr = scc_address;
        o_scc_wdata = scc_write_data;
      end
      if (mem_read) begin
        o_mem_rd++;
        o_mem_addr = mem_address;
      end
      if (mem_write) begin
        o_mem_wr++;
        o_mem_addr = mem_address;
        o_mem_wdata = mem_write_data;
      end
      if (bus_read_ready) begin
        o_rdy++;
        o_rdata = bus_read_data;
        o_lat = c;
      end
      mem_busy = (c <= busy);
      if (mem_read && !mem_busy && rwait >= 0) mem_due = c + 1 + rwait;
      scc_read_ready = (c == scc_due);
      scc_read_data  = (c == scc_due) ? resp : 8'h00;
      mem_read_valid = (c == mem_due);
      mem_read_data  = (c == mem_due) ? resp : 8'h00;
      @(negedge clk);
    end
    mem_busy = 1'b0; scc_read_ready = 1'b0; mem_read_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    run(v.rd, v.wr, v.memc, v.addr, v.wd, v.resp, v.rwait, 0, 12);
    check({v.name, " scc_read"}, o_scc_rd, v.e_scc_rd);
    check({v.name, " scc_write"}, o_scc_wr, v.e_scc_wr);
    check({v.name, " mem_read"}, o_mem_rd, v.e_mem_rd);
    check({v.name, " mem_write"}, o_mem_wr, v.e_mem_wr);
    check({v.name, " ready"}, o_rdy, v.e_rdy);
    if (v.e_scc_rd + v.e_scc_wr > 0) check({v.name, " scc_address"}, o_scc_addr, v.e_scc_addr);
    if (v.e_scc_wr > 0) check({v.name, " scc_write_data"}, o_scc_wdata, v.e_wdata);
    if (v.e_mem_rd + v.e_mem_wr > 0) check({v.name, " mem_address"}, o_mem_addr, v.e_mem_addr);
    if (v.e_mem_wr > 0) check({v.name, " mem_write_data"}, o_mem_wdata, v.e_wdata);
    if (v.e_rdy > 0) begin
      check({v.name, " read_data"}, o_rdata, v.e_rdata);
      check({v.name, " latency"}, o_lat, v.e_lat);
    end
    check({v.name, " flags"}, {scc_bank_en, sccp_bank_en, sccp_en}, v.e_flags);
  endtask

  initial begin : main
    int n_rd, n_rdy, n_scc;
    logic [7:0] rdata_seen;
    int lat_seen;

    //          name       rd    wr    mem   addr      wd     resp   w   srd swr mrd mwr
    //          scc_addr   wdata  mem_addr    rdy rdata lat flags
    vecs[0]  = '{"rd9800", 1'b1, 1'b0, 1'b1, 16'h9800, 8'h00, 8'h11, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h05800, 1, 8'h11, 3, 3'b000};
    vecs[1]  = '{"bank2=3F", 1'b0, 1'b1, 1'b1, 16'h9000, 8'h3f, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[2]  = '{"sccrd9880", 1'b1, 1'b0, 1'b1, 16'h9880, 8'h00, 8'h5a, 3, 1, 0, 0, 0,
                 16'h9880, 8'h00, 21'h0, 1, 8'h5a, 5, 3'b100};
    vecs[3]  = '{"sccwr9810", 1'b0, 1'b1, 1'b1, 16'h9810, 8'h77, 8'h00, 0, 0, 1, 0, 0,
                 16'h9810, 8'h77, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[4]  = '{"mode=20", 1'b0, 1'b1, 1'b1, 16'hbffe, 8'h20, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b001};
    vecs[5]  = '{"bank3=80", 1'b0, 1'b1, 1'b1, 16'hb000, 8'h80, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b011};
    vecs[6]  = '{"sccrdB800", 1'b1, 1'b0, 1'b1, 16'hb800, 8'h00, 8'h3c, 1, 1, 0, 0, 0,
                 16'hb800, 8'h00, 21'h0, 1, 8'h3c, 3, 3'b011};
    vecs[7]  = '{"rd9800p", 1'b1, 1'b0, 1'b1, 16'h9800, 8'h00, 8'h99, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h7f800, 1, 8'h99, 3, 3'b011};
    vecs[8]  = '{"wrBFFEscc", 1'b0, 1'b1, 1'b1, 16'hbffe, 8'h10, 8'h00, 0, 0, 1, 0, 0,
                 16'hbffe, 8'h10, 21'h0, 0, 8'h00, 0, 3'b011};
    vecs[9]  = '{"bank3=03", 1'b0, 1'b1, 1'b1, 16'hb000, 8'h03, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b001};
    vecs[10] = '{"modeBFFF=10", 1'b0, 1'b1, 1'b1, 16'hbfff, 8'h10, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[11] = '{"ramwr6000", 1'b0, 1'b1, 1'b1, 16'h6000, 8'haa, 8'h00, 0, 0, 0, 0, 1,
                 16'h0000, 8'haa, 21'h02000, 0, 8'h00, 0, 3'b100};
    vecs[12] = '{"ramwr7000", 1'b0, 1'b1, 1'b1, 16'h7000, 8'h55, 8'h00, 0, 0, 0, 0, 1,
                 16'h0000, 8'h55, 21'h03000, 0, 8'h00, 0, 3'b100};
    vecs[13] = '{"rd7000", 1'b1, 1'b0, 1'b1, 16'h7000, 8'h00, 8'h42, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h03000, 1, 8'h42, 3, 3'b100};
    vecs[14] = '{"ramwr9000", 1'b0, 1'b1, 1'b1, 16'h9000, 8'h11, 8'h00, 0, 0, 0, 0, 1,
                 16'h0000, 8'h11, 21'h7f000, 0, 8'h00, 0, 3'b100};
    vecs[15] = '{"mode=00", 1'b0, 1'b1, 1'b1, 16'hbffe, 8'h00, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[16] = '{"romwr6000", 1'b0, 1'b1, 1'b1, 16'h6000, 8'haa, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[17] = '{"bank0=07", 1'b0, 1'b1, 1'b1, 16'h5000, 8'h07, 8'h00, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[18] = '{"rd4123", 1'b1, 1'b0, 1'b1, 16'h4123, 8'h00, 8'h01, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h0e123, 1, 8'h01, 3, 3'b100};
    vecs[19] = '{"rd0000", 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h77, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[20] = '{"rdC000", 1'b1, 1'b0, 1'b1, 16'hc000, 8'h00, 8'h77, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};
    vecs[21] = '{"rd+wr6000", 1'b1, 1'b1, 1'b1, 16'h6000, 8'hff, 8'h6e, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h02000, 1, 8'h6e, 3, 3'b100};
    vecs[22] = '{"io9800", 1'b1, 1'b0, 1'b0, 16'h9800, 8'h00, 8'h77, 0, 0, 0, 0, 0,
                 16'h0000, 8'h00, 21'h0, 0, 8'h00, 0, 3'b100};

    post[0]  = '{"rst_b0", 1'b1, 1'b0, 1'b1, 16'h4000, 8'h00, 8'h21, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h00000, 1, 8'h21, 3, 3'b000};
    post[1]  = '{"rst_b1", 1'b1, 1'b0, 1'b1, 16'h6000, 8'h00, 8'h22, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h02000, 1, 8'h22, 3, 3'b000};
    post[2]  = '{"rst_b2", 1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, 8'h23, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h04000, 1, 8'h23, 3, 3'b000};
    post[3]  = '{"rst_b3", 1'b1, 1'b0, 1'b1, 16'ha000, 8'h00, 8'h24, 0, 0, 0, 1, 0,
                 16'h0000, 8'h00, 21'h06000, 1, 8'h24, 3, 3'b000};

    n_reset = 1'b0;
    bus_address = '0; bus_write_data = '0; bus_read = 1'b0; bus_write = 1'b0;
    bus_memory = 1'b0; scc_read_ready = 1'b0; scc_read_data = '0; mem_busy = 1'b0;
    mem_read_data = '0; mem_read_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    check("reset ready", bus_read_ready, 1'b0);
    check("reset read_data", bus_read_data, 8'h00);
    check("reset strobes", {scc_read, scc_write, mem_read, mem_write}, 4'b0000);
    check("reset mem_address", mem_address, 21'h0);
    check("reset scc_address", scc_address, 16'h0);
    check("reset flags", {scc_bank_en, sccp_bank_en, sccp_en}, 3'b000);

    foreach (vecs[i]) apply(vecs[i]);

    // Memory stalls 5 cycles then never returns data: abort with no ready, data kept
    run(1'b1, 1'b0, 1'b1, 16'h4000, 8'h00, 8'h00, -1, 5, 70);
    check("stall mem_read cycles", o_mem_rd, 6);
    check("stall mem_address", o_mem_addr, 21'h0e000);
    check("timeout no ready", o_rdy, 0);
    check("timeout data kept", bus_read_data, 8'h6e);
    run(1'b1, 1'b0, 1'b1, 16'h4000, 8'h00, 8'h5c, 0, 0, 12);
    check("after timeout ready", o_rdy, 1);
    check("after timeout data", o_rdata, 8'h5c);

    // Requests during MEM_RD and on the cycle the FSM returns to IDLE are dropped
    n_rd = 0; n_rdy = 0; rdata_seen = '0; lat_seen = 0;
    @(negedge clk);
    bus_read = 1'b1; bus_memory = 1'b1; bus_address = 16'h4000;
    @(negedge clk);
    bus_read = 1'b0; bus_memory = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_read) n_rd++;
      if (bus_read_ready) begin
        n_rdy++;
        rdata_seen = bus_read_data;
        lat_seen = c;
      end
      bus_read = (c == 2 || c == 3);
      bus_memory = (c == 2 || c == 3);
      bus_address = 16'h8000;
      mem_read_valid = (c == 3);
      mem_read_data = (c == 3) ? 8'h6a : 8'h00;
      @(negedge clk);
    end
    check("busy req mem_read cycles", n_rd, 1);
    check("busy req ready count", n_rdy, 1);
    check("busy req data", rdata_seen, 8'h6a);
    check("busy req latency", lat_seen, 4);

    // Reset in the middle of an SCC read; late scc_read_ready must be ignored
    @(negedge clk);
    bus_read = 1'b1; bus_memory = 1'b1; bus_address = 16'h9800;
    @(negedge clk);
    bus_read = 1'b0; bus_memory = 1'b0;
    check("pre-reset scc_read", scc_read, 1'b1);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("mid reset read_data", bus_read_data, 8'h00);
    check("mid reset scc_address", scc_address, 16'h0);
    check("mid reset strobes", {bus_read_ready, scc_read, mem_read, mem_write}, 4'b0000);
    check("mid reset flags", {scc_bank_en, sccp_bank_en, sccp_en}, 3'b000);
    @(negedge clk);
    n_reset = 1'b1;
    n_rdy = 0; n_scc = 0;
    for (int c = 3; c <= 12; c++) begin
      if (bus_read_ready) n_rdy++;
      if (scc_read || mem_read) n_scc++;
      scc_read_ready = (c <= 4);
      scc_read_data = 8'hee;
      @(negedge clk);
    end
    scc_read_ready = 1'b0;
    check("late ready ignored", n_rdy, 0);
    check("no strobe after reset", n_scc, 0);

    foreach (post[i]) apply(post[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
